// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared MEM-stage FSM encoding and MEM/WB bubble values
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [4:0]  BUBBLE_RD       = 5'd0;
  localparam logic        BUBBLE_REGWRITE = 1'b0;
  localparam logic [31:0] BUBBLE_WB_DATA  = 32'd0;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/acknowledge bus
interface mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ack_timer.sv
// rtl/mem_stage_ack_timer.sv - mem_ack_timer: WAIT-cycle counter with timeout expiry flag
module mem_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // count holds WAIT cycles already spent; the IDLE request cycle and the
  // current WAIT cycle add two more stall cycles to the total.
  assign expired = ({1'b0, count} + 9'd2) == 9'(ACK_TIMEOUT);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, stall, timeout abort, MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        EX_MEM_ALU_result,
  input  logic [31:0]        EX_MEM_rs2_data,
  input  logic [4:0]         EX_MEM_rd,
  input  logic               EX_MEM_regwrite,
  input  logic               EX_MEM_memtoreg,
  input  logic               EX_MEM_memread,
  input  logic               EX_MEM_memwrite,
  mem_stage_if.master        dmem,
  output logic               MEM_stall,
  output logic               MEM_bus_error,
  output logic [4:0]         MEM_WB_rd,
  output logic               MEM_WB_regwrite,
  output logic [31:0]        MEM_WB_wb_data
);

  localparam logic ABORT_FROM_IDLE = (ACK_TIMEOUT == 1);

  state_t state;
  state_t next_state;
  logic   mem_op;
  logic   is_load;
  logic   timer_expired;
  logic   stall;
  logic   bus_error;

  assign mem_op  = EX_MEM_memread | EX_MEM_memwrite;
  assign is_load = EX_MEM_memread & ~EX_MEM_memwrite;

  assign dmem.dmem_we    = EX_MEM_memwrite;
  assign dmem.dmem_addr  = EX_MEM_ALU_result[31:2];
  assign dmem.dmem_wdata = EX_MEM_rs2_data;

  mem_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != WAIT),
    .en      ((state == WAIT) && !dmem.dmem_ack),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    dmem.dmem_req = 1'b0;
    stall         = 1'b0;
    bus_error     = 1'b0;
    case (state)
      IDLE: begin
        dmem.dmem_req = mem_op;
        if (mem_op && !dmem.dmem_ack) begin
          stall      = 1'b1;
          next_state = ABORT_FROM_IDLE ? ABORT : WAIT;
        end
      end
      WAIT: begin
        dmem.dmem_req = 1'b1;
        if (dmem.dmem_ack) begin
          next_state = IDLE;
        end else begin
          stall = 1'b1;
          if (timer_expired) begin
            next_state = ABORT;
          end
        end
      end
      ABORT: begin
        bus_error  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign MEM_stall     = stall;
  assign MEM_bus_error = bus_error;

  // Stalled and aborted cycles retire a bubble so write-back never repeats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_WB_rd       <= BUBBLE_RD;
      MEM_WB_regwrite <= BUBBLE_REGWRITE;
      MEM_WB_wb_data  <= BUBBLE_WB_DATA;
    end else if (stall || (state == ABORT)) begin
      MEM_WB_rd       <= BUBBLE_RD;
      MEM_WB_regwrite <= BUBBLE_REGWRITE;
      MEM_WB_wb_data  <= BUBBLE_WB_DATA;
    end else begin
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_regwrite <= EX_MEM_regwrite;
      MEM_WB_wb_data  <= (EX_MEM_memtoreg && is_load) ? dmem.dmem_rdata : EX_MEM_ALU_result;
    end
  end

endmodule
